// File: rtl/mips_bus_arbiter_if.sv
// Bus bundle for the two-master arbiter: master request/response pairs plus
// the shared memory port and the UART CSR port.
interface mips_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic                  m0_wr_en;
    logic [DATA_WIDTH-1:0] m0_wr_data;
    logic                  m0_gnt;
    logic                  m0_rd_valid;
    logic [DATA_WIDTH-1:0] m0_rd_data;

    logic                  m1_req;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic                  m1_wr_en;
    logic [DATA_WIDTH-1:0] m1_wr_data;
    logic                  m1_gnt;
    logic                  m1_rd_valid;
    logic [DATA_WIDTH-1:0] m1_rd_data;

    logic                  mem_chip_sel;
    logic [ADDR_WIDTH-2:0] mem_addr;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    logic                  uart_csr_wen;
    logic                  uart_csr_ren;
    logic [2:0]            uart_csr_addr;
    logic [DATA_WIDTH-1:0] uart_csr_wr_data;
    logic [DATA_WIDTH-1:0] uart_csr_rd_data;

    logic                  busy;

    modport slave (
        input  m0_req, m0_addr, m0_wr_en, m0_wr_data,
        input  m1_req, m1_addr, m1_wr_en, m1_wr_data,
        input  mem_rd_data, uart_csr_rd_data,
        output m0_gnt, m0_rd_valid, m0_rd_data,
        output m1_gnt, m1_rd_valid, m1_rd_data,
        output mem_chip_sel, mem_addr, mem_wr_en, mem_wr_data,
        output uart_csr_wen, uart_csr_ren, uart_csr_addr, uart_csr_wr_data,
        output busy
    );

    modport master (
        output m0_req, m0_addr, m0_wr_en, m0_wr_data,
        output m1_req, m1_addr, m1_wr_en, m1_wr_data,
        output mem_rd_data, uart_csr_rd_data,
        input  m0_gnt, m0_rd_valid, m0_rd_data,
        input  m1_gnt, m1_rd_valid, m1_rd_data,
        input  mem_chip_sel, mem_addr, mem_wr_en, mem_wr_data,
        input  uart_csr_wen, uart_csr_ren, uart_csr_addr, uart_csr_wr_data,
        input  busy
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter between two bus masters sharing memory and the UART CSR
// port; each access runs IDLE -> ACCESS -> (WAIT -> RESP) with registered outputs.
module mips_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    mips_bus_arbiter_if.slave  bus
);
    localparam int         MSB   = ADDR_WIDTH - 1;
    localparam logic [2:0] LAT_C = 3'(MEM_RD_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic                  win_r, win_s;
    logic                  last_r, last_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic                  wr_en_r, wr_en_s;
    logic [DATA_WIDTH-1:0] wr_data_r, wr_data_s;
    logic [2:0]            cnt_r, cnt_s;
    logic [1:0]            gnt_r, gnt_s;
    logic [1:0]            rv_r, rv_s;
    logic [DATA_WIDTH-1:0] rd0_r, rd0_s, rd1_r, rd1_s;
    logic                  cs_r, cs_s, mwe_r, mwe_s, cwen_r, cwen_s, cren_r, cren_s;
    logic                  busy_r, busy_s;

    logic                  pick_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic                  sel_wr_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [DATA_WIDTH-1:0] rdata_s;

    // Round-robin pick (ties go to the master not granted last) and target read mux
    always_comb begin
        if (bus.m0_req && bus.m1_req) begin
            pick_s = ~last_r;
        end else begin
            pick_s = bus.m1_req;
        end
        if (pick_s) begin
            sel_addr_s = bus.m1_addr;
            sel_wr_s   = bus.m1_wr_en;
            sel_data_s = bus.m1_wr_data;
        end else begin
            sel_addr_s = bus.m0_addr;
            sel_wr_s   = bus.m0_wr_en;
            sel_data_s = bus.m0_wr_data;
        end
        if (addr_r[MSB]) begin
            rdata_s = bus.uart_csr_rd_data;
        end else begin
            rdata_s = bus.mem_rd_data;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_s   = state_r;
        win_s     = win_r;
        last_s    = last_r;
        addr_s    = addr_r;
        wr_en_s   = wr_en_r;
        wr_data_s = wr_data_r;
        cnt_s     = cnt_r;
        gnt_s     = 2'b00;
        rv_s      = 2'b00;
        rd0_s     = rd0_r;
        rd1_s     = rd1_r;
        cs_s      = 1'b0;
        mwe_s     = 1'b0;
        cwen_s    = 1'b0;
        cren_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_s   = S_ACCESS;
                    win_s     = pick_s;
                    addr_s    = sel_addr_s;
                    wr_en_s   = sel_wr_s;
                    wr_data_s = sel_data_s;
                    if (!sel_addr_s[MSB]) begin
                        cs_s  = 1'b1;
                        mwe_s = sel_wr_s;
                    end else if (sel_wr_s) begin
                        cwen_s = 1'b1;
                    end else begin
                        cren_s = 1'b1;
                    end
                    // Writes complete in the strobe cycle, so their gnt rides with it
                    if (sel_wr_s) begin
                        gnt_s[pick_s] = 1'b1;
                    end else begin
                        gnt_s = 2'b00;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (wr_en_r) begin
                    state_s = S_IDLE;
                    last_s  = win_r;
                end else begin
                    state_s = S_WAIT;
                    if (addr_r[MSB]) begin
                        cnt_s = 3'd1;
                    end else begin
                        cnt_s = LAT_C;
                    end
                end
            end
            S_WAIT: begin
                cnt_s = cnt_r - 3'd1;
                if (cnt_r == 3'd1) begin
                    state_s       = S_RESP;
                    gnt_s[win_r]  = 1'b1;
                    rv_s[win_r]   = 1'b1;
                    if (win_r) begin
                        rd1_s = rdata_s;
                    end else begin
                        rd0_s = rdata_s;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_RESP: begin
                state_s = S_IDLE;
                last_s  = win_r;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        busy_s = (state_s != S_IDLE) ? 1'b1 : 1'b0;
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            win_r     <= 1'b0;
            last_r    <= 1'b1;
            addr_r    <= '0;
            wr_en_r   <= 1'b0;
            wr_data_r <= '0;
            cnt_r     <= 3'd0;
            gnt_r     <= 2'b00;
            rv_r      <= 2'b00;
            rd0_r     <= '0;
            rd1_r     <= '0;
            cs_r      <= 1'b0;
            mwe_r     <= 1'b0;
            cwen_r    <= 1'b0;
            cren_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            win_r     <= win_s;
            last_r    <= last_s;
            addr_r    <= addr_s;
            wr_en_r   <= wr_en_s;
            wr_data_r <= wr_data_s;
            cnt_r     <= cnt_s;
            gnt_r     <= gnt_s;
            rv_r      <= rv_s;
            rd0_r     <= rd0_s;
            rd1_r     <= rd1_s;
            cs_r      <= cs_s;
            mwe_r     <= mwe_s;
            cwen_r    <= cwen_s;
            cren_r    <= cren_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.m0_gnt           = gnt_r[0];
    assign bus.m1_gnt           = gnt_r[1];
    assign bus.m0_rd_valid      = rv_r[0];
    assign bus.m1_rd_valid      = rv_r[1];
    assign bus.m0_rd_data       = rd0_r;
    assign bus.m1_rd_data       = rd1_r;
    assign bus.mem_chip_sel     = cs_r;
    assign bus.mem_wr_en        = mwe_r;
    assign bus.mem_addr         = addr_r[ADDR_WIDTH-2:0];
    assign bus.mem_wr_data      = wr_data_r;
    assign bus.uart_csr_wen     = cwen_r;
    assign bus.uart_csr_ren     = cren_r;
    assign bus.uart_csr_addr    = addr_r[2:0];
    assign bus.uart_csr_wr_data = wr_data_r;
    assign bus.busy             = busy_r;
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: masters push expected transactions,
// a negedge monitor checks strobes, arbitration order, latency and read data.
module tb_mips_bus_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk;
    logic rst;

    mips_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mips_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_RD_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    int          gnt_log[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] ref_mem [logic [30:0]];
    logic [31:0] dev_mem [logic [30:0]];

    int          mem_due  = -1;
    int          uart_due = -1;
    logic [31:0] mem_q    = 32'd0;
    logic [31:0] uart_q   = 32'd0;

    logic        prev_req0 = 1'b0;
    logic        prev_req1 = 1'b0;
    logic        last_win  = 1'b1;
    bit          active    = 1'b0;
    int          pend_win  = 0;
    int          stb_cyc   = 0;
    logic [31:0] exp_rd0   = 32'd0;
    logic [31:0] exp_rd1   = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_default(input logic [30:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [31:0] uart_val(input logic [2:0] a);
        return 32'hCAFE_0000 + 32'(a) * 32'h0000_0101;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Memory and UART device models: data is valid only in the due cycle
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.mem_rd_data      = (cyc == mem_due)  ? mem_q  : $urandom;
            bus.uart_csr_rd_data = (cyc == uart_due) ? uart_q : $urandom;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_chip_sel === 1'b1) begin
                if (bus.mem_wr_en === 1'b1) begin
                    dev_mem[bus.mem_addr] = bus.mem_wr_data;
                end else begin
                    mem_q   = dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr] : mem_default(bus.mem_addr);
                    mem_due = cyc + LAT;
                end
            end
            if (bus.uart_csr_ren === 1'b1) begin
                uart_q   = uart_val(bus.uart_csr_addr);
                uart_due = cyc + 1;
            end
        end
    end

    task automatic monitor_cycle();
        int          nstb;
        int          w;
        bit          ok;
        bit          have;
        txn_t        t;
        logic [31:0] exp_d;
        int          exp_lat;
        nstb = int'(bus.mem_chip_sel) + int'(bus.uart_csr_wen) + int'(bus.uart_csr_ren);
        ok = (nstb <= 1) && !(bus.mem_wr_en && !bus.mem_chip_sel)
             && !(bus.m0_rd_valid && !bus.m0_gnt) && !(bus.m1_rd_valid && !bus.m1_gnt);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL protocol: cs/wen/ren/mwe/g0/rv0/g1/rv1=%b required one strobe max, wr_en only with cs, rd_valid only with gnt",
                     {bus.mem_chip_sel, bus.uart_csr_wen, bus.uart_csr_ren, bus.mem_wr_en,
                      bus.m0_gnt, bus.m0_rd_valid, bus.m1_gnt, bus.m1_rd_valid});
        end
        if (nstb != 0) begin
            check_eq("strobe_while_busy", 32'(active), 32'd0);
            check_eq("strobe_without_req", 32'(prev_req0 | prev_req1), 32'd1);
            if (prev_req0 && prev_req1) w = last_win ? 0 : 1;
            else                        w = prev_req1 ? 1 : 0;
            have = (w == 0) ? (q0.size() > 0) : (q1.size() > 0);
            checks++;
            if (!have) begin
                failures++;
                $display("FAIL strobe_no_txn: strobe seen, expected winner m%0d has no pending transaction", w);
            end else begin
                t = (w == 0) ? q0[0] : q1[0];
                if (!t.addr[31]) begin
                    ok = bus.mem_chip_sel && (bus.mem_addr == t.addr[30:0]) && (bus.mem_wr_en == t.wr)
                         && (!t.wr || bus.mem_wr_data == t.data) && !bus.uart_csr_wen && !bus.uart_csr_ren;
                end else begin
                    ok = !bus.mem_chip_sel && (t.wr ? (bus.uart_csr_wen && !bus.uart_csr_ren)
                                                    : (bus.uart_csr_ren && !bus.uart_csr_wen))
                         && (bus.uart_csr_addr == t.addr[2:0]) && (!t.wr || bus.uart_csr_wr_data == t.data);
                end
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL strobe: got cs=%b mwe=%b maddr=%h wen=%b ren=%b caddr=%0d wdata=%h expected m%0d wr=%b addr=%h data=%h",
                             bus.mem_chip_sel, bus.mem_wr_en, bus.mem_addr, bus.uart_csr_wen, bus.uart_csr_ren,
                             bus.uart_csr_addr, bus.mem_wr_data, w, t.wr, t.addr, t.data);
                end
            end
            active   = 1'b1;
            pend_win = w;
            stb_cyc  = cyc;
        end
        check_eq("busy", 32'(bus.busy), 32'(active));
        if (bus.m0_gnt || bus.m1_gnt) begin
            w = bus.m1_gnt ? 1 : 0;
            have = (w == 0) ? (q0.size() > 0) : (q1.size() > 0);
            checks++;
            if (!active || (bus.m0_gnt && bus.m1_gnt) || w != pend_win || !have) begin
                failures++;
                $display("FAIL gnt_owner: got g0=%b g1=%b expected single gnt to m%0d of an active transaction (active=%0d)",
                         bus.m0_gnt, bus.m1_gnt, pend_win, active);
            end else begin
                t = (w == 0) ? q0.pop_front() : q1.pop_front();
                exp_lat = t.wr ? 0 : (t.addr[31] ? 2 : LAT + 1);
                check_eq("gnt_latency", 32'(cyc - stb_cyc), 32'(exp_lat));
                check_eq("rd_valid", 32'((w == 0) ? bus.m0_rd_valid : bus.m1_rd_valid), 32'(!t.wr));
                if (t.wr) begin
                    if (!t.addr[31]) ref_mem[t.addr[30:0]] = t.data;
                end else begin
                    if (t.addr[31])                   exp_d = uart_val(t.addr[2:0]);
                    else if (ref_mem.exists(t.addr[30:0])) exp_d = ref_mem[t.addr[30:0]];
                    else                              exp_d = mem_default(t.addr[30:0]);
                    if (w == 0) exp_rd0 = exp_d;
                    else        exp_rd1 = exp_d;
                end
                last_win = (w == 1);
                gnt_log.push_back(w);
            end
            active = 1'b0;
        end
        check_eq("m0_rd_data", bus.m0_rd_data, exp_rd0);
        check_eq("m1_rd_data", bus.m1_rd_data, exp_rd1);
        prev_req0 = bus.m0_req;
        prev_req1 = bus.m1_req;
    endtask

    // Monitor: reset clears the reference state, otherwise check every cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                q0.delete();
                q1.delete();
                active    = 1'b0;
                last_win  = 1'b1;
                exp_rd0   = 32'd0;
                exp_rd1   = 32'd0;
                prev_req0 = 1'b0;
                prev_req1 = 1'b0;
            end else begin
                monitor_cycle();
            end
        end
    end

    task automatic drive(input int m, input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_wr_en = wr; bus.m0_addr = a; bus.m0_wr_data = d;
        end else begin
            bus.m1_req = req; bus.m1_wr_en = wr; bus.m1_addr = a; bus.m1_wr_data = d;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) bus.m0_req = 1'b0;
        else        bus.m1_req = 1'b0;
    endtask

    task automatic issue(input int m, input logic wr, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        bit   got;
        t.wr = wr; t.addr = a; t.data = d;
        if (m == 0) q0.push_back(t);
        else        q1.push_back(t);
        drive(m, 1'b1, wr, a, d);
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((m == 0 && bus.m0_gnt === 1'b1) || (m == 1 && bus.m1_gnt === 1'b1)) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL gnt_timeout: m%0d got no gnt within 64 cycles, required a gnt", m);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check_eq("reset_ctrl", {23'd0, bus.m0_gnt, bus.m0_rd_valid, bus.m1_gnt, bus.m1_rd_valid,
                                bus.mem_chip_sel, bus.mem_wr_en, bus.uart_csr_wen, bus.uart_csr_ren, bus.busy}, 32'd0);
        check_eq("reset_m0_rd_data", bus.m0_rd_data, 32'd0);
        check_eq("reset_m1_rd_data", bus.m1_rd_data, 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drop(0);
        drop(1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset();
    endtask

    task automatic master_rand(input int m, input int n);
        logic [31:0] a;
        logic        wr;
        int          gap;
        for (int i = 0; i < n; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom;
                a[31] = 1'b1;
            end else begin
                a = 32'($urandom_range(0, 15));
            end
            issue(m, wr, a, $urandom);
            gap = $urandom_range(0, 2);
            if (gap != 0 || i == n - 1) begin
                drop(m);
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        txn_t t;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        bus.mem_rd_data      = 32'd0;
        bus.uart_csr_rd_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;

        // Directed single-master accesses
        issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF); drop(0);
        dev_mem[31'h20] = 32'h1234_5678;
        ref_mem[31'h20] = 32'h1234_5678;
        issue(1, 1'b0, 32'h0000_0020, 32'd0);         drop(1);
        issue(0, 1'b0, 32'h8000_0005, 32'd0);         drop(0);
        issue(1, 1'b1, 32'h8000_0FF9, 32'h0000_00A5); drop(1);
        issue(0, 1'b0, 32'h0000_0010, 32'd0);         drop(0);
        check_eq("readback_deadbeef", bus.m0_rd_data, 32'hDEAD_BEEF);

        // Simultaneous requests right after reset alternate starting with m0
        pulse_reset();
        @(posedge clk);
        #1;
        gnt_log.delete();
        fork
            begin
                issue(0, 1'b1, 32'h0000_0014, 32'h0000_00A0);
                issue(0, 1'b0, 32'h8000_0002, 32'd0);
                drop(0);
            end
            begin
                issue(1, 1'b0, 32'h0000_0014, 32'd0);
                issue(1, 1'b1, 32'h0000_0018, 32'h0000_00B1);
                drop(1);
            end
        join
        check_eq("tie_count", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("tie_order", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'd9, 32'(i % 2));
        end

        // Reset while m1's memory read sits in WAIT
        t.wr = 1'b0; t.addr = 32'h0000_0040; t.data = 32'd0;
        q1.push_back(t);
        drive(1, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_chip_sel === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("abort_strobe_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drop(1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset();
        repeat (4) @(posedge clk);
        #1;
        gnt_log.delete();
        fork
            begin issue(0, 1'b1, 32'h0000_0044, 32'h1111_1111); drop(0); end
            begin issue(1, 1'b1, 32'h0000_0048, 32'h2222_2222); drop(1); end
        join
        check_eq("tie_after_abort", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'd9, 32'd0);

        // Randomized concurrent traffic from both masters
        fork
            master_rand(0, 40);
            master_rand(1, 40);
        join
        repeat (10) @(posedge clk);
        check_eq("q0_drained", 32'(q0.size()), 32'd0);
        check_eq("q1_drained", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master bus arbiter and transaction sequencer for the MIPS+UART SoC. It sits between the MIPS core (master 0) and a second bus master such as a DMA or debug loader (master 1), and shares the single instruction/data memory and the UART CSR port between them. It decodes address bit MSB exactly as the SoC memory map does: 0 selects memory, 1 selects UART. It grants masters round-robin, and sequences each access through fixed strobe, wait and response cycles.

## Interface
- ADDR_WIDTH, 32, master address width; memory address is ADDR_WIDTH-1 bits.
- DATA_WIDTH, 32, data width for masters, memory and UART CSR.
- MEM_RD_LATENCY, 1, memory read latency in cycles after the strobe cycle; legal range 1..4.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_req  in  1  master N (N=0,1) request; level, held until mN_gnt.
- mN_addr  in  ADDR_WIDTH  master N address.
- mN_wr_en  in  1  1 = write, 0 = read.
- mN_wr_data  in  DATA_WIDTH  write data.
- mN_gnt  out  1  one-cycle pulse; transaction complete.
- mN_rd_valid  out  1  one-cycle pulse with mN_gnt on reads.
- mN_rd_data  out  DATA_WIDTH  read data, valid when mN_rd_valid.
- mem_chip_sel  out  1  memory strobe.
- mem_addr  out  ADDR_WIDTH-1  memory address.
- mem_wr_en  out  1  memory write enable, only with mem_chip_sel.
- mem_wr_data  out  DATA_WIDTH  memory write data.
- mem_rd_data  in  DATA_WIDTH  memory read data.
- uart_csr_wen  out  1  UART CSR write strobe.
- uart_csr_ren  out  1  UART CSR read strobe.
- uart_csr_addr  out  3  UART CSR address.
- uart_csr_wr_data  out  DATA_WIDTH  CSR write data.
- uart_csr_rd_data  in  DATA_WIDTH  CSR read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, RESP.
- **IDLE:**
  - If any req is high, arbitrate and latch the winner's addr, wr_en and wr_data, plus winner id.
  - Go to ACCESS.
- **Arbitration:**
  - A single requester wins.
  - If both request, the master not granted last wins.
  - last_gnt resets to 1, so m0 wins the first tie.
- **Decode of latched addr:**
  - MSB = 0: memory, mem_addr = addr[ADDR_WIDTH-2:0].
  - MSB = 1: UART, uart_csr_addr = addr[2:0]; bits [ADDR_WIDTH-2:3] are ignored.
- **ACCESS:**
  - Drive exactly one strobe for one cycle: mem_chip_sel (with mem_wr_en = wr_en), uart_csr_wen, or uart_csr_ren.
  - Write: assert winner gnt in this same cycle, update last_gnt, go to IDLE.
  - Read: load the wait counter with MEM_RD_LATENCY for memory or 1 for UART, go to WAIT.
- **WAIT:**
  - No strobes; address and data outputs hold the latched values.
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, register the target read data into mN_rd_data of the winner and go to RESP.
- **RESP:** assert winner gnt and rd_valid, update last_gnt, go to IDLE.
- **Request hand-off:** a req still high in the IDLE cycle after gnt is treated as a new request. Masters must drop req in the cycle after gnt unless issuing another transaction.
- **Non-winning master:** the losing master's req stays pending and is not disturbed. It wins the next arbitration if the other master re-requests.
- mN_rd_data holds its last value until that master's next read completes.

## Timing
- **Reset values:** state IDLE, all gnt/rd_valid/strobes 0, rd_data 0, last_gnt 1, counter 0, busy 0.
- **Write latency** (req sampled in IDLE at cycle T):
  - Strobe and gnt at T+1.
  - Next arbitration at T+2.
- **Read latency:**
  - Strobe at T+1.
  - WAIT covers T+2..T+1+L.
  - gnt/rd_valid at T+2+L.
  - Next arbitration at T+3+L.
  - L = MEM_RD_LATENCY for memory, 1 for UART.
- **Throughput:**
  - Back-to-back writes: one transaction per 2 cycles.
  - With both masters continuously requesting, grants strictly alternate (no starvation).
- **Reset asserted mid-transaction:**
  - Abort in the next cycle with no gnt issued and strobes deasserted.
  - The aborted master must re-request.
- Memory and UART strobes are never asserted in the same cycle.

## Test plan
- **m0 write to memory:** m0 writes 0xDEADBEEF to 0x0000_0010 → mem_chip_sel=1, mem_wr_en=1, mem_addr=0x10 at T+1; m0_gnt pulse at T+1; busy low at T+2.
- **m1 read from memory, MEM_RD_LATENCY=2:** memory returns 0x12345678 → m1_gnt and m1_rd_valid at T+4 with m1_rd_data=0x12345678; m0 outputs unchanged.
- **m0 read from UART CSR:** m0 reads 0x8000_0005 → uart_csr_ren=1, uart_csr_addr=5 at T+1; rd_valid at T+3 with the CSR value; mem_chip_sel stays 0 throughout.
- **Simultaneous requests after reset:** both masters request together for 4 transactions → grant order m0, m1, m0, m1.
- **Reset during WAIT:** assert rst during a m1 memory read's WAIT state → no m1_gnt; all outputs at reset values the next cycle; a subsequent tie goes to m0.
- **Write to UART 0x8000_0FF9:** uart_csr_wen=1 with uart_csr_addr=1 (upper bits ignored); no memory strobe.
